exu_wbck_ctrl: RTL and testbench
================================

# exu_wbck_ctrl

Writeback controller for the EXU general-purpose register file. It shares the file's single write port between the single-cycle ALU and the long-latency pipe (LSU/MULDIV), and tracks the destinations of outstanding long-latency ops in a scoreboard. It flags RAW/WAW hazards to dispatch and bounds ALU starvation with a counter. It sits between the EXU result buses and the register file's `wbck_dest_*` write port.

## Interface
- `XLEN`, 32, datapath width
- `RFIDX_WIDTH`, 5, register index width
- `RFREG_NUM`, 32, number of architectural registers
- `STARVE_LIMIT`, 3, consecutive ALU losses before the ALU gets forced priority (≥1)

- `clk` in 1 — clock; one clock domain, all state updates on the rising edge
- `rst` in 1 — reset, synchronous, active-high
- `alu_wbck_valid` in 1 — ALU result available
- `alu_wbck_ready` out 1 — ALU result accepted this cycle
- `alu_wbck_idx` in RFIDX_WIDTH — ALU destination
- `alu_wbck_data` in XLEN — ALU result
- `lng_wbck_valid` in 1 — long-pipe result available
- `lng_wbck_ready` out 1 — long-pipe result accepted this cycle
- `lng_wbck_idx` in RFIDX_WIDTH — long-pipe destination
- `lng_wbck_data` in XLEN — long-pipe result
- `disp_lng_valid` in 1 — long op dispatched this cycle; sets its scoreboard bit
- `disp_lng_idx` in RFIDX_WIDTH — dispatched op destination
- `chk_src1_idx`, `chk_src2_idx`, `chk_dest_idx` in RFIDX_WIDTH — operands of the instruction at dispatch
- `chk_src1_en`, `chk_src2_en`, `chk_dest_en` in 1 — operand used
- `dep_stall` out 1 — a used operand hits a pending long destination
- `wbck_dest_ena` out 1 — register file write enable
- `wbck_dest_idx` out RFIDX_WIDTH — register file write index
- `wbck_dest_data` out XLEN — register file write data
- `sb_busy` out 1 — one or more scoreboard bits set

## Operation
- **Arbitration** (combinational within the cycle):
  - Default priority goes to the long pipe.
  - If `starve_cnt == STARVE_LIMIT` and both sources are valid, the ALU wins.
  - Exactly one `*_ready` is high when any valid is high. The non-granted source's ready is 0.
- **Handshake:** a transfer completes when valid && ready. Sources hold idx/data stable while valid && !ready.
- **Write port:**
  - `wbck_dest_idx` and `wbck_dest_data` are muxed from the granted source.
  - `wbck_dest_ena` = transfer && idx != 0.
  - Writes to x0 are accepted (ready=1) but produce no write.
  - With no valid source: `wbck_dest_ena` = 0 and idx/data = 0.
- **Scoreboard:** `RFREG_NUM` bits; bit 0 is tied to 0.
  - Set on `disp_lng_valid` with idx != 0.
  - Cleared on a completed long-pipe transfer.
  - When set and clear hit the same index in the same cycle, set wins.
  - An ALU write to a pending index is a protocol error: the write proceeds and the bit is unchanged.
- **dep_stall:** OR over enabled operands (src1, src2, dest) of `sb[idx]`, computed from the registered scoreboard only (no same-cycle clear bypass). Index 0 never stalls.
- **sb_busy:** OR of all scoreboard bits.
- **starve_cnt:** width is clog2(STARVE_LIMIT+1).
  - Increments when `alu_wbck_valid` is high and the long pipe is granted.
  - Clears when the ALU is granted or `alu_wbck_valid` is 0.
  - Saturates at `STARVE_LIMIT`.

## Timing
- **Reset:**
  - Scoreboard = 0 and `starve_cnt` = 0.
  - While `rst` is high: both readies = 0, `wbck_dest_ena` = 0, `wbck_dest_idx` / `wbck_dest_data` = 0, `dep_stall` = 0, `sb_busy` = 0.
  - Reset asserted mid-operation discards all pending bits at the next edge.
- **Write latency:** 0 cycles from grant to the write-port outputs. The register file captures the write at the same rising edge that completes the transfer.
- **Scoreboard visibility:**
  - A set by `disp_lng_valid` in cycle N is visible on `dep_stall` / `sb_busy` from cycle N+1.
  - A clear by a long transfer in cycle N drops `dep_stall` from cycle N+1.
  - The cleared register's data is readable from the file from cycle N+1.
- **Starvation bound:** an ALU source held valid is granted within `STARVE_LIMIT`+1 cycles, whatever the long pipe does.
- **Dispatch responsibility:** the dispatcher must not assert `disp_lng_valid` while `dep_stall` is high for that instruction. This block does not gate it.

## Test plan
1. Reset, then drive `alu_wbck_valid` with idx=5, data=0xDEADBEEF for one cycle -> `alu_wbck_ready`=1, `wbck_dest_ena`=1, idx=5 in that cycle; x5 reads 0xDEADBEEF in the next cycle.
2. Both sources valid continuously (ALU idx=3, long idx=4) with `STARVE_LIMIT`=3 -> long granted cycles 0-2, ALU granted cycle 3, then long again. The grant pattern repeats every 4 cycles.
3. `disp_lng_valid` idx=7 in cycle 0; `chk_src1` idx=7 enabled from cycle 1 -> `dep_stall`=1 and `sb_busy`=1 from cycle 1. Long writeback idx=7 completes in cycle 4 -> `dep_stall`=0 and `sb_busy`=0 from cycle 5.
4. Writeback to x0 from each source -> ready=1, `wbck_dest_ena`=0. `disp_lng_valid` idx=0 -> `sb_busy` stays 0, and `chk_dest` idx=0 never stalls.
5. Same cycle: long writeback completes idx=9 (bit set) and `disp_lng_valid` idx=9 -> bit 9 remains set the next cycle.
6. Set bits 2 and 6, then assert `rst` for one cycle while `lng_wbck_valid`=1 -> no write during reset; `sb_busy`=0, `dep_stall`=0 and `starve_cnt`=0 after the edge.

Source files
------------

// File: rtl/exu_wbck_ctrl.sv
// exu_wbck_ctrl: shares the GPR file write port between the single-cycle ALU
// and the long-latency pipe. It keeps a scoreboard of pending long-op
// destinations for dependency checks, and uses a counter to bound ALU
// starvation.
//
// Handshake: a source transfers in any cycle where valid && ready. A source
// holds idx/data stable while valid && !ready. Exactly one ready is high
// whenever any valid is high and rst is low. A write to x0 is accepted but
// does not assert wbck_dest_ena.
module exu_wbck_ctrl #(
  parameter int XLEN         = 32,
  parameter int RFIDX_WIDTH  = 5,
  parameter int RFREG_NUM    = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wbck_valid,
  output logic                   alu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]        alu_wbck_data,
  input  logic                   lng_wbck_valid,
  output logic                   lng_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] lng_wbck_idx,
  input  logic [XLEN-1:0]        lng_wbck_data,
  input  logic                   disp_lng_valid,
  input  logic [RFIDX_WIDTH-1:0] disp_lng_idx,
  input  logic [RFIDX_WIDTH-1:0] chk_src1_idx,
  input  logic [RFIDX_WIDTH-1:0] chk_src2_idx,
  input  logic [RFIDX_WIDTH-1:0] chk_dest_idx,
  input  logic                   chk_src1_en,
  input  logic                   chk_src2_en,
  input  logic                   chk_dest_en,
  output logic                   dep_stall,
  output logic                   wbck_dest_ena,
  output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]        wbck_dest_data,
  output logic                   sb_busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [CW-1:0]        starve_cnt;
  logic [CW-1:0]        starve_nxt;
  logic [RFREG_NUM-1:0] sb;
  logic [RFREG_NUM-1:0] sb_nxt;
  logic                 starved;
  logic                 alu_grant;
  logic                 lng_grant;

  // Arbitration: the long pipe wins by default. The ALU wins when it is
  // alone, or when it has lost STARVE_LIMIT times in a row.
  always_comb begin
    starved   = (starve_cnt == STARVE_MAX);
    alu_grant = !rst && alu_wbck_valid && (!lng_wbck_valid || starved);
    lng_grant = !rst && lng_wbck_valid && !alu_grant;
    alu_wbck_ready = alu_grant;
    lng_wbck_ready = lng_grant;
  end

  // Write port mux: it drives zeros when nothing is granted, and it suppresses
  // writes to x0.
  always_comb begin
    wbck_dest_idx  = '0;
    wbck_dest_data = '0;
    if (alu_grant) begin
      wbck_dest_idx  = alu_wbck_idx;
      wbck_dest_data = alu_wbck_data;
    end else if (lng_grant) begin
      wbck_dest_idx  = lng_wbck_idx;
      wbck_dest_data = lng_wbck_data;
    end
    wbck_dest_ena = (alu_grant || lng_grant) && (wbck_dest_idx != '0);
  end

  // Next state for the starvation counter and the scoreboard. For the
  // scoreboard, a dispatch set overrides a same-cycle writeback clear.
  always_comb begin
    starve_nxt = '0;
    if (alu_wbck_valid && lng_grant) begin
      starve_nxt = starved ? starve_cnt : starve_cnt + CW'(1);
    end
    sb_nxt = sb;
    if (lng_grant && (lng_wbck_idx != '0)) begin
      sb_nxt[lng_wbck_idx] = 1'b0;
    end
    if (disp_lng_valid && (disp_lng_idx != '0)) begin
      sb_nxt[disp_lng_idx] = 1'b1;
    end
    sb_nxt[0] = 1'b0;
  end

  // State registers; reset discards all pending destinations.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      sb         <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      sb         <= sb_nxt;
    end
  end

  // Hazard flags come from the registered scoreboard only. There is no
  // bypass of a same-cycle clear.
  always_comb begin
    dep_stall = !rst && ((chk_src1_en && sb[chk_src1_idx]) ||
                         (chk_src2_en && sb[chk_src2_idx]) ||
                         (chk_dest_en && sb[chk_dest_idx]));
    sb_busy   = !rst && (|sb);
  end

endmodule

// File: tb/tb_exu_wbck_ctrl.sv
// Bench for exu_wbck_ctrl. It runs directed vectors with literal expectations,
// plus a behavioural reference model that is compared on every cycle.
module tb_exu_wbck_ctrl;

  localparam int XLEN         = 32;
  localparam int RFIDX_WIDTH  = 5;
  localparam int RFREG_NUM    = 32;
  localparam int STARVE_LIMIT = 3;

  logic                   clk;
  logic                   rst;
  logic                   alu_wbck_valid;
  logic                   alu_wbck_ready;
  logic [RFIDX_WIDTH-1:0] alu_wbck_idx;
  logic [XLEN-1:0]        alu_wbck_data;
  logic                   lng_wbck_valid;
  logic                   lng_wbck_ready;
  logic [RFIDX_WIDTH-1:0] lng_wbck_idx;
  logic [XLEN-1:0]        lng_wbck_data;
  logic                   disp_lng_valid;
  logic [RFIDX_WIDTH-1:0] disp_lng_idx;
  logic [RFIDX_WIDTH-1:0] chk_src1_idx;
  logic [RFIDX_WIDTH-1:0] chk_src2_idx;
  logic [RFIDX_WIDTH-1:0] chk_dest_idx;
  logic                   chk_src1_en;
  logic                   chk_src2_en;
  logic                   chk_dest_en;
  logic                   dep_stall;
  logic                   wbck_dest_ena;
  logic [RFIDX_WIDTH-1:0] wbck_dest_idx;
  logic [XLEN-1:0]        wbck_dest_data;
  logic                   sb_busy;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] rf [RFREG_NUM];

  // Reference model state: consecutive ALU losses and the set of pending
  // long-op destinations.
  int m_loss;
  bit m_pend [RFREG_NUM];

  exu_wbck_ctrl #(
    .XLEN(XLEN), .RFIDX_WIDTH(RFIDX_WIDTH), .RFREG_NUM(RFREG_NUM), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_idx(alu_wbck_idx), .alu_wbck_data(alu_wbck_data),
    .lng_wbck_valid(lng_wbck_valid), .lng_wbck_ready(lng_wbck_ready),
    .lng_wbck_idx(lng_wbck_idx), .lng_wbck_data(lng_wbck_data),
    .disp_lng_valid(disp_lng_valid), .disp_lng_idx(disp_lng_idx),
    .chk_src1_idx(chk_src1_idx), .chk_src2_idx(chk_src2_idx), .chk_dest_idx(chk_dest_idx),
    .chk_src1_en(chk_src1_en), .chk_src2_en(chk_src2_en), .chk_dest_en(chk_dest_en),
    .dep_stall(dep_stall), .wbck_dest_ena(wbck_dest_ena),
    .wbck_dest_idx(wbck_dest_idx), .wbck_dest_data(wbck_dest_data), .sb_busy(sb_busy)
  );

  // Clock and a register-file sink on the write port.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wbck_dest_ena) rf[wbck_dest_idx] <= wbck_dest_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alu_wbck_valid = 1'b0; alu_wbck_idx = '0; alu_wbck_data = '0;
    lng_wbck_valid = 1'b0; lng_wbck_idx = '0; lng_wbck_data = '0;
    disp_lng_valid = 1'b0; disp_lng_idx = '0;
    chk_src1_idx = '0; chk_src2_idx = '0; chk_dest_idx = '0;
    chk_src1_en = 1'b0; chk_src2_en = 1'b0; chk_dest_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the reference model. The model then advances
  // using this cycle's inputs, which stay stable until the next rising edge.
  always @(negedge clk) begin
    logic e_alu, e_lng, e_ena, e_stall, e_busy;
    logic [RFIDX_WIDTH-1:0] e_idx;
    logic [XLEN-1:0] e_data;
    e_alu = 0; e_lng = 0; e_ena = 0; e_stall = 0; e_busy = 0; e_idx = '0; e_data = '0;
    if (!rst) begin
      e_alu = alu_wbck_valid && (!lng_wbck_valid || m_loss >= STARVE_LIMIT);
      e_lng = lng_wbck_valid && !e_alu;
      if (e_alu) begin
        e_idx = alu_wbck_idx; e_data = alu_wbck_data;
      end else if (e_lng) begin
        e_idx = lng_wbck_idx; e_data = lng_wbck_data;
      end
      e_ena   = (e_alu || e_lng) && (e_idx != 0);
      e_stall = (chk_src1_en && m_pend[chk_src1_idx]) || (chk_src2_en && m_pend[chk_src2_idx]) ||
                (chk_dest_en && m_pend[chk_dest_idx]);
      for (int i = 0; i < RFREG_NUM; i++) e_busy |= m_pend[i];
    end
    chk("m_alu_ready", 32'(alu_wbck_ready), 32'(e_alu));
    chk("m_lng_ready", 32'(lng_wbck_ready), 32'(e_lng));
    chk("m_ena", 32'(wbck_dest_ena), 32'(e_ena));
    chk("m_idx", 32'(wbck_dest_idx), 32'(e_idx));
    chk("m_data", wbck_dest_data, e_data);
    chk("m_dep_stall", 32'(dep_stall), 32'(e_stall));
    chk("m_sb_busy", 32'(sb_busy), 32'(e_busy));
    if (rst) begin
      m_loss = 0;
      for (int i = 0; i < RFREG_NUM; i++) m_pend[i] = 0;
    end else begin
      m_loss = (alu_wbck_valid && e_lng) ? ((m_loss + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_loss + 1) : 0;
      if (e_lng) m_pend[lng_wbck_idx] = 0;
      if (disp_lng_valid && disp_lng_idx != 0) m_pend[disp_lng_idx] = 1;
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    m_loss = 0;
    for (int i = 0; i < RFREG_NUM; i++) begin m_pend[i] = 0; rf[i] = '0; end
    idle();
    rst = 1'b1;
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd1; lng_wbck_data = 32'h1111;
    @(negedge clk);
    chk("rst_lng_ready", 32'(lng_wbck_ready), 32'd0);
    chk("rst_ena", 32'(wbck_dest_ena), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle();

    // T1: single ALU write to x5.
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd5; alu_wbck_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_alu_ready", 32'(alu_wbck_ready), 32'd1);
    chk("t1_ena", 32'(wbck_dest_ena), 32'd1);
    chk("t1_idx", 32'(wbck_dest_idx), 32'd5);
    tick();
    idle();
    @(negedge clk);
    chk("t1_rf5", rf[5], 32'hDEADBEEF);
    tick();

    // T2: both sources valid. The grant pattern is L,L,L,A repeated.
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd3; alu_wbck_data = 32'h33;
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd4; lng_wbck_data = 32'h44;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_lng_ready", 32'(lng_wbck_ready), (i % 4 == 3) ? 32'd0 : 32'd1);
      chk("t2_alu_ready", 32'(alu_wbck_ready), (i % 4 == 3) ? 32'd1 : 32'd0);
      tick();
    end
    idle();

    // T3: dispatch to x7, stall on src1, then clear by a long writeback.
    disp_lng_valid = 1'b1; disp_lng_idx = 5'd7;
    @(negedge clk);
    chk("t3_busy_c0", 32'(sb_busy), 32'd0);
    tick();
    idle();
    chk_src1_idx = 5'd7; chk_src1_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t3_stall", 32'(dep_stall), 32'd1);
      chk("t3_busy", 32'(sb_busy), 32'd1);
      tick();
    end
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd7; lng_wbck_data = 32'h77;
    @(negedge clk);
    chk("t3_lng_ready_c4", 32'(lng_wbck_ready), 32'd1);
    chk("t3_stall_c4", 32'(dep_stall), 32'd1);
    tick();
    lng_wbck_valid = 1'b0;
    @(negedge clk);
    chk("t3_stall_c5", 32'(dep_stall), 32'd0);
    chk("t3_busy_c5", 32'(sb_busy), 32'd0);
    chk("t3_rf7", rf[7], 32'h77);
    tick();
    idle();

    // T4: writes to x0 from each source, dispatch to x0.
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd0; alu_wbck_data = 32'h1234;
    @(negedge clk);
    chk("t4_alu_ready", 32'(alu_wbck_ready), 32'd1);
    chk("t4_alu_ena", 32'(wbck_dest_ena), 32'd0);
    tick();
    idle();
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd0; lng_wbck_data = 32'h5678;
    @(negedge clk);
    chk("t4_lng_ready", 32'(lng_wbck_ready), 32'd1);
    chk("t4_lng_ena", 32'(wbck_dest_ena), 32'd0);
    tick();
    idle();
    disp_lng_valid = 1'b1; disp_lng_idx = 5'd0;
    tick();
    idle();
    chk_dest_idx = 5'd0; chk_dest_en = 1'b1;
    @(negedge clk);
    chk("t4_busy", 32'(sb_busy), 32'd0);
    chk("t4_stall", 32'(dep_stall), 32'd0);
    tick();
    idle();

    // T5: same-cycle clear and set of x9, set wins.
    disp_lng_valid = 1'b1; disp_lng_idx = 5'd9;
    tick();
    idle();
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd9; lng_wbck_data = 32'h99;
    disp_lng_valid = 1'b1; disp_lng_idx = 5'd9;
    @(negedge clk);
    chk("t5_lng_ready", 32'(lng_wbck_ready), 32'd1);
    tick();
    idle();
    chk_src2_idx = 5'd9; chk_src2_en = 1'b1;
    @(negedge clk);
    chk("t5_stall", 32'(dep_stall), 32'd1);
    chk("t5_busy", 32'(sb_busy), 32'd1);
    tick();
    idle();
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd9; lng_wbck_data = 32'h9A;
    tick();
    idle();
    @(negedge clk);
    chk("t5_busy_clr", 32'(sb_busy), 32'd0);
    tick();

    // T6: pending bits and a saturated starve count are discarded by reset.
    disp_lng_valid = 1'b1; disp_lng_idx = 5'd2;
    tick();
    disp_lng_idx = 5'd6;
    tick();
    idle();
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd3; alu_wbck_data = 32'h3;
    lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd2; lng_wbck_data = 32'h2;
    @(negedge clk);
    chk("t6_busy_pre", 32'(sb_busy), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_lng_ready", 32'(lng_wbck_ready), 32'd0);
    chk("t6_rst_alu_ready", 32'(alu_wbck_ready), 32'd0);
    chk("t6_rst_ena", 32'(wbck_dest_ena), 32'd0);
    tick();
    rst = 1'b0;
    chk_src1_idx = 5'd2; chk_src1_en = 1'b1;
    chk_src2_idx = 5'd6; chk_src2_en = 1'b1;
    @(negedge clk);
    chk("t6_stall", 32'(dep_stall), 32'd0);
    chk("t6_busy", 32'(sb_busy), 32'd0);
    chk("t6_lng_wins", 32'(lng_wbck_ready), 32'd1);
    tick();
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
